// File: rtl/decoder_addr_sequencer.sv
// decoder_addr_sequencer: queues 2-bit select requests and replays each as a clean enable strobe for a 2-to-4 decoder
module decoder_addr_sequencer #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic [1:0]                 req_addr,
    output logic                       req_ready,
    output logic                       addr0,
    output logic                       addr1,
    output logic                       enable,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int MX = PULSE_CYCLES > GAP_CYCLES ? PULSE_CYCLES : GAP_CYCLES;
    localparam int NW = $clog2(MX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [NW-1:0] P_LD = NW'(PULSE_CYCLES - 1);
    localparam logic [NW-1:0] G_LD = NW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t        state, state_nx;
    logic [NW-1:0] cnt, cnt_nx;
    logic          en_nx, pop, push;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [1:0]    mem [DEPTH];

    assign req_ready = count < FULL;
    assign push      = req_valid & req_ready;
    assign busy      = (state != IDLE) | (count != '0);

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= req_addr;

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end

    // Strobe FSM state, dwell counter and registered decoder drive
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            enable <= 1'b0;
            addr0  <= 1'b0;
            addr1  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            enable <= en_nx;
            addr0  <= pop ? mem[rd_ptr][0] : addr0;
            addr1  <= pop ? mem[rd_ptr][1] : addr1;
        end

    // Next state: pulse for PULSE_CYCLES, rest for GAP_CYCLES, pop on every new pulse
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        en_nx    = enable;
        pop      = 1'b0;
        case (state)
            IDLE:
                if (count != '0) begin
                    pop      = 1'b1;
                    en_nx    = 1'b1;
                    cnt_nx   = P_LD;
                    state_nx = DRIVE;
                end
            DRIVE:
                if (cnt != '0) cnt_nx = cnt - NW'(1);
                else if (GAP_CYCLES > 0) begin
                    en_nx    = 1'b0;
                    cnt_nx   = G_LD;
                    state_nx = GAP;
                end else if (count != '0) begin
                    pop    = 1'b1;
                    cnt_nx = P_LD;
                end else begin
                    en_nx    = 1'b0;
                    state_nx = IDLE;
                end
            GAP:
                if (cnt != '0) cnt_nx = cnt - NW'(1);
                else if (count != '0) begin
                    pop      = 1'b1;
                    en_nx    = 1'b1;
                    cnt_nx   = P_LD;
                    state_nx = DRIVE;
                end else state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_decoder_addr_sequencer.sv
// tb_decoder_addr_sequencer: directed checks of the sequencer in default, zero-gap and long-pulse configurations
module tb_decoder_addr_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_valid = 1'b0, g_valid = 1'b0, s_valid = 1'b0;
    logic [1:0] d_req = '0, g_req = '0, s_req = '0;
    logic       d_ready, d_a0, d_a1, d_en, d_busy;
    logic       g_ready, g_a0, g_a1, g_en, g_busy;
    logic       s_ready, s_a0, s_a1, s_en, s_busy;
    logic [2:0] d_count, g_count, s_count;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    decoder_addr_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .req_valid(d_valid), .req_addr(d_req), .req_ready(d_ready),
        .addr0(d_a0), .addr1(d_a1), .enable(d_en), .busy(d_busy), .count(d_count));

    decoder_addr_sequencer #(.DEPTH(4), .PULSE_CYCLES(3), .GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst_n(rst_n), .req_valid(g_valid), .req_addr(g_req), .req_ready(g_ready),
        .addr0(g_a0), .addr1(g_a1), .enable(g_en), .busy(g_busy), .count(g_count));

    decoder_addr_sequencer #(.DEPTH(4), .PULSE_CYCLES(8), .GAP_CYCLES(1)) u_st (
        .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_addr(s_req), .req_ready(s_ready),
        .addr0(s_a0), .addr1(s_a1), .enable(s_en), .busy(s_busy), .count(s_count));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp4 [4];
        logic       prev;
        int         got;
        exp4 = '{2'd1, 2'd2, 2'd3, 2'd2};

        // 1: reset values, then idle
        tick();
        tick();
        chk("rst_en", d_en, 0);
        chk("rst_a0", d_a0, 0);
        chk("rst_a1", d_a1, 0);
        chk("rst_count", d_count, 0);
        chk("rst_ready", d_ready, 1);
        chk("rst_busy", d_busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_en", d_en, 0);
        end

        // 2: single request 2'b10
        d_valid = 1'b1;
        d_req   = 2'b10;
        tick();
        d_valid = 1'b0;
        chk("single_queued", d_count, 1);
        chk("single_en_lat", d_en, 0);
        tick();
        chk("single_en", d_en, 1);
        chk("single_addr", {d_a1, d_a0}, 2'b10);
        chk("single_dec", d_en ? 4'(4'b0001 << {d_a1, d_a0}) : 4'b0000, 4'b0100);
        chk("single_count", d_count, 0);
        tick();
        chk("single_off", d_en ? 4'(4'b0001 << {d_a1, d_a0}) : 4'b0000, 4'b0000);
        chk("single_busy_gap", d_busy, 1);
        chk("single_hold", {d_a1, d_a0}, 2'b10);
        tick();
        chk("single_busy_end", d_busy, 0);

        // 3: burst 0,1,2,3 -> 1,0,1,0,... with addresses in order
        d_valid = 1'b1;
        d_req   = 2'd0;
        tick();
        for (int k = 0; k < 8; k++) begin
            d_valid = (k < 3);
            d_req   = 2'(k + 1);
            tick();
            chk("burst_en", d_en, (k % 2 == 0));
            if (d_en) chk("burst_addr", {d_a1, d_a0}, k / 2);
        end
        chk("burst_busy_gap", d_busy, 1);
        tick();
        chk("burst_busy_end", d_busy, 0);

        // 4: full FIFO behind a long first pulse
        s_valid = 1'b1;
        s_req   = 2'd3;
        tick();
        s_valid = 1'b0;
        tick();
        chk("stall_en", s_en, 1);
        chk("stall_addr", {s_a1, s_a0}, 3);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_req   = 2'(i);
            tick();
        end
        chk("full_count", s_count, 4);
        chk("full_ready", s_ready, 0);
        s_req = 2'd2;
        repeat (3) tick();
        chk("full_pulse_last", s_en, 1);
        chk("full_hold_count", s_count, 4);
        tick();
        chk("full_pulse_done", s_en, 0);
        chk("full_gap_count", s_count, 4);
        tick();
        chk("full_pop_en", s_en, 1);
        chk("full_pop_addr", {s_a1, s_a0}, 0);
        chk("full_no_accept", s_count, 3);
        chk("full_ready_back", s_ready, 1);
        tick();
        s_valid = 1'b0;
        chk("fifth_accepted", s_count, 4);
        prev = s_en;
        got  = 0;
        for (int t = 0; t < 200 && got < 4; t++) begin
            tick();
            if (s_en && !prev) begin
                chk("drain_order", {s_a1, s_a0}, exp4[got]);
                got++;
            end
            prev = s_en;
        end
        chk("drain_all", got, 4);

        // 5: async reset in the middle of a pulse
        d_valid = 1'b1;
        d_req   = 2'd3;
        tick();
        d_req = 2'd1;
        tick();
        d_valid = 1'b0;
        chk("mid_en", d_en, 1);
        chk("mid_count", d_count, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", d_en, 0);
        chk("arst_addr", {d_a1, d_a0}, 0);
        chk("arst_count", d_count, 0);
        chk("arst_ready", d_ready, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_no_stale", d_en, 0);
        end

        // 6: PULSE_CYCLES=3, GAP_CYCLES=0 back-to-back
        g_valid = 1'b1;
        g_req   = 2'd1;
        tick();
        g_req = 2'd3;
        for (int k = 0; k < 6; k++) begin
            tick();
            g_valid = 1'b0;
            chk("b2b_en", g_en, 1);
            chk("b2b_addr", {g_a1, g_a0}, k < 3 ? 1 : 3);
        end
        tick();
        chk("b2b_off", g_en, 0);
        chk("b2b_busy", g_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
